// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain controller of the async FIFO.
// Syncs the Gray write pointer, owns the read pointers and
// produces empty, fill count, memory read enable and a
// valid strobe aligned to the registered memory read data.
//
// Ports:
//   rd_clk, rd_rst  read clock, async active-high reset
//   rd_req          consumer wants one word this cycle
//   wr_ptr_gray     raw Gray write pointer (unsynchronized)
//   rd_en, rd_addr  memory read port
//   rd_ptr_gray     registered Gray read pointer
//   empty, rd_count registered status
//   rd_valid        memory rd_data valid this cycle
//   almost_empty    only with FIFO_RD_ALMOST_EMPTY_EN
//
// Optional feature macro: FIFO_RD_ALMOST_EMPTY_EN
module fifo_rd_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_req,
  input  logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic                 rd_en,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [ADDR_SIZE:0]   rd_ptr_gray,
  output logic                 empty,
  output logic [ADDR_SIZE:0]   rd_count,
  output logic                 rd_valid
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic                 almost_empty
`endif
);

  logic [ADDR_SIZE:0] wq1_q, wq1_d;
  logic [ADDR_SIZE:0] wq2_q, wq2_d;
  logic [ADDR_SIZE:0] rbin_q, rbin_d;
  logic [ADDR_SIZE:0] rgray_q, rgray_d;
  logic [ADDR_SIZE:0] count_q, count_d;
  logic               empty_q, empty_d;
  logic               valid_q, valid_d;
  logic [ADDR_SIZE:0] wbin;
  logic               rd_en_c;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [ADDR_SIZE:0] AE_LIM =
    (ADDR_SIZE+1)'(AE_THRESH);
  logic ae_q, ae_d;
`else
  // Threshold only matters in the almost-empty build.
  localparam int unused_ae_thresh = AE_THRESH;
`endif

  // empty_q is a flop, so rd_en never loops back on itself.
  assign rd_en_c = rd_req & ~empty_q;

  always_comb begin
    wq1_d = wr_ptr_gray;
    wq2_d = wq1_q;

    // Gray to binary: bit i is the XOR of bits i and above.
    wbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      wbin[i] = ^(wq2_q >> i);
    end

    rbin_d  = rbin_q + {{ADDR_SIZE{1'b0}}, rd_en_c};
    rgray_d = (rbin_d >> 1) ^ rbin_d;

    // Uses the post-read pointer against the current sync
    // value: may hold empty one extra cycle, never drops early.
    empty_d = (rgray_d == wq2_q);
    count_d = wbin - rbin_d;
    valid_d = rd_en_c;
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  always_comb begin
    ae_d = (count_d <= AE_LIM);
  end
`endif

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      wq1_q   <= '0;
      wq2_q   <= '0;
      rbin_q  <= '0;
      rgray_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      wq1_q   <= wq1_d;
      wq2_q   <= wq2_d;
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      count_q <= count_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      ae_q <= 1'b1;
    end else begin
      ae_q <= ae_d;
    end
  end

  assign almost_empty = ae_q;
`endif

  assign rd_en       = rd_en_c;
  assign rd_addr     = rbin_q[ADDR_SIZE-1:0];
  assign rd_ptr_gray = rgray_q;
  assign empty       = empty_q;
  assign rd_count    = count_q;
  assign rd_valid    = valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: random + directed stimulus with a queue
// scoreboard against a word-count model of the read side.
module tb_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int AE = 2;

  logic          clk;
  logic          rd_rst;
  logic          rd_req;
  logic [AW:0]   wr_ptr_gray;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr_gray;
  logic          empty;
  logic [AW:0]   rd_count;
  logic          rd_valid;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic          almost_empty;
`endif

  fifo_rd_ctrl #(.ADDR_SIZE(AW), .AE_THRESH(AE)) dut (
    .rd_clk      (clk),
    .rd_rst      (rd_rst),
    .rd_req      (rd_req),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .rd_count    (rd_count),
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    .almost_empty(almost_empty),
`endif
    .rd_valid    (rd_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit empty;
    int count;
    int gray;
    bit valid;
    bit en;
    int addr;
    bit ae;
  } rec_t;

  rec_t rq[$];
  int   dq[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Model: whole-word counts, no modulo arithmetic.
  // s1/s2 are the write counts the read side has seen
  // one and two edges after the writer published them.
  int wp_tot, r_tot, s1, s2, m_count;
  bit m_empty, m_valid, m_ae;

  function automatic int gray(input int v);
    logic [AW:0] b;
    b = (AW+1)'(v % 32);
    return int'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string nm,
                     input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int wp);
    wp_tot  = wp;
    r_tot   = 0;
    s1      = 0;
    s2      = 0;
    m_count = 0;
    m_empty = 1'b1;
    m_valid = 1'b0;
    m_ae    = 1'b1;
    dq.delete();
  endtask

  task automatic model_edge();
    bit en;
    int rn;
    if (rd_rst) return;
    en      = rd_req && !m_empty;
    rn      = r_tot + (en ? 1 : 0);
    m_empty = (rn == s2);
    m_count = s2 - rn;
    m_ae    = (m_count <= AE);
    m_valid = en;
    s2      = s1;
    s1      = wp_tot;
    r_tot   = rn;
  endtask

  task automatic push_rec();
    rec_t e;
    e.empty = m_empty;
    e.count = m_count;
    e.gray  = gray(r_tot);
    e.valid = m_valid;
    e.en    = rd_req && !m_empty;
    e.addr  = r_tot % 16;
    e.ae    = m_ae;
    rq.push_back(e);
    if (e.en) dq.push_back(e.addr);
  endtask

  task automatic cycle(input bit rst_v, input bit req_v,
                       input int wp_v);
    @(posedge clk);
    model_edge();
    #1;
    rd_rst      = rst_v;
    rd_req      = req_v;
    wp_tot      = wp_v;
    wr_ptr_gray = (AW+1)'(gray(wp_v));
    if (rst_v) model_reset(wp_v);
    push_rec();
  endtask

  // Monitor: pops one status record per cycle, and one
  // expected read address per rd_valid.
  initial begin
    rec_t        e;
    int          exp_a;
    int          last_a;
    logic [AW:0] prev_g;
    bit          prev_ok;
    last_a  = 0;
    prev_g  = '0;
    prev_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("empty", int'(empty), int'(e.empty));
        chk("rd_count", int'(rd_count), e.count);
        chk("rd_ptr_gray", int'(rd_ptr_gray), e.gray);
        chk("rd_valid", int'(rd_valid), int'(e.valid));
        chk("rd_en", int'(rd_en), int'(e.en));
        chk("rd_addr", int'(rd_addr), e.addr);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        chk("almost_empty", int'(almost_empty),
            int'(e.ae));
`endif
      end
      if (rd_valid) begin
        if (dq.size() == 0) begin
          chk("valid_without_read", 1, 0);
        end else begin
          exp_a = dq.pop_front();
          chk("read_data_addr", last_a, exp_a);
        end
      end
      if (rd_en) last_a = int'(rd_addr);
      if (!rd_rst && prev_ok && rd_ptr_gray != prev_g)
        chk("gray_one_bit_step",
            $countones(rd_ptr_gray ^ prev_g), 1);
      prev_g  = rd_ptr_gray;
      prev_ok = !rd_rst;
    end
  end

  initial begin
    int w;
    bit req;
    rd_rst      = 1'b1;
    rd_req      = 1'b1;
    wr_ptr_gray = 5'b00011;
    model_reset(2);

    // Reset with a pending request and a nonzero pointer.
    repeat (3) cycle(1, 1, 2);
    repeat (2) cycle(0, 0, 0);

    // Underflow: requests against an empty FIFO.
    repeat (10) cycle(0, 1, 0);

    // Single word.
    repeat (8) cycle(0, 1, 1);

    // Fill to 16, drain, repeat across the pointer wrap.
    for (int k = 0; k < 3; k++) begin
      w = r_tot + 16;
      repeat (5) cycle(0, 0, w);
      repeat (18) cycle(0, 1, w);
    end

    // Almost-empty walk from 5 words down.
    w = r_tot + 5;
    repeat (5) cycle(0, 0, w);
    repeat (7) cycle(0, 1, w);

    // Reset in the middle of a burst after 3 reads.
    w = r_tot + 8;
    repeat (5) cycle(0, 0, w);
    repeat (3) cycle(0, 1, w);
    repeat (2) cycle(1, 1, 0);
    repeat (3) cycle(0, 1, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        repeat (2) cycle(1, 1'($urandom_range(0, 1)), 0);
      end else begin
        req = ($urandom_range(0, 3) != 0);
        w   = wp_tot;
        if ((wp_tot - r_tot) < 16) begin
          if (((i / 200) % 2) == 0) begin
            if ($urandom_range(0, 2) != 0) w++;
          end else begin
            if ($urandom_range(0, 2) == 0) w++;
          end
        end
        cycle(0, req, w);
      end
    end

    // Drain everything still published.
    repeat (24) cycle(0, 1, wp_tot);
    repeat (4) cycle(0, 0, wp_tot);

    @(negedge clk);
    #1;
    chk("record_queue_drained", rq.size(), 0);
    chk("read_queue_drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
